// File: rtl/cook_timer.sv
// Microwave cook timer: keypad BCD entry of MM:SS, countdown gated by mag_on, done flag.
// Optional end-of-cook beep pulse when TIMER_BEEP_EN is defined.
module cook_timer #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned BEEP_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
`ifdef TIMER_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2 || BEEP_CYCLES < 1) begin : g_bad_param
    $error("cook_timer: TICK_DIV must be >= 2 and BEEP_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic          done_d;
  logic [3:0]    min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;

  logic key_ok_c;
  logic tick_c;

  assign key_ok_c = digit_valid && !mag_on && (digit <= 4'd9);
  assign tick_c   = mag_on && (state == SET || state == RUN) &&
                    (presc == PW'(TICK_DIV - 1));

  // State, count, prescaler and done register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      timer_done <= 1'b0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
    end else begin
      state      <= state_d;
      presc      <= presc_d;
      timer_done <= done_d;
      min_tens   <= min_tens_d;
      min_ones   <= min_ones_d;
      sec_tens   <= sec_tens_d;
      sec_ones   <= sec_ones_d;
    end
  end

  // Next-state: clear beats key entry beats countdown
  always_comb begin
    state_d    = state;
    presc_d    = presc;
    done_d     = timer_done;
    min_tens_d = min_tens;
    min_ones_d = min_ones;
    sec_tens_d = sec_tens;
    sec_ones_d = sec_ones;

    if (!clearn) begin
      state_d    = IDLE;
      presc_d    = '0;
      done_d     = 1'b0;
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (key_ok_c) begin
      done_d = 1'b0;
      if (state == DONE) begin
        min_tens_d = 4'd0;
        min_ones_d = 4'd0;
        sec_tens_d = 4'd0;
      end else begin
        min_tens_d = min_ones;
        min_ones_d = sec_tens;
        sec_tens_d = sec_ones;
      end
      sec_ones_d = digit;
      if ({min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} == 16'd0) begin
        state_d = IDLE;
        presc_d = '0;
      end else begin
        state_d = SET;
      end
    end else if (state == IDLE) begin
      // Start with nothing set finishes at once
      if (mag_on) begin
        done_d  = 1'b1;
        state_d = DONE;
      end
    end else if (state == SET || state == RUN) begin
      if (mag_on) begin
        state_d = RUN;
        if (tick_c) begin
          presc_d = '0;
          if (sec_ones != 4'd0) begin
            sec_ones_d = sec_ones - 4'd1;
          end else if (sec_tens != 4'd0) begin
            sec_tens_d = sec_tens - 4'd1;
            sec_ones_d = 4'd9;
          end else if (min_ones != 4'd0) begin
            min_ones_d = min_ones - 4'd1;
            sec_tens_d = 4'd5;
            sec_ones_d = 4'd9;
          end else begin
            min_tens_d = min_tens - 4'd1;
            min_ones_d = 4'd9;
            sec_tens_d = 4'd5;
            sec_ones_d = 4'd9;
          end
          if ({min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} == 16'd0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          presc_d = presc + PW'(1);
        end
      end else begin
        state_d = SET;
      end
    end
  end

`ifdef TIMER_BEEP_EN
  localparam int unsigned BW = (BEEP_CYCLES > 2) ? $clog2(BEEP_CYCLES) : 1;

  logic [BW-1:0] beep_cnt, beep_cnt_d;
  logic          beep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else begin
      beep     <= beep_d;
      beep_cnt <= beep_cnt_d;
    end
  end

  // Pulse starts with the done rise and lasts BEEP_CYCLES cycles
  always_comb begin
    beep_d     = beep;
    beep_cnt_d = beep_cnt;
    if (!clearn || key_ok_c) begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (done_d && !timer_done) begin
      beep_d     = 1'b1;
      beep_cnt_d = '0;
    end else if (beep) begin
      if (beep_cnt == BW'(BEEP_CYCLES - 1)) begin
        beep_d = 1'b0;
      end else begin
        beep_cnt_d = beep_cnt + BW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICK_DIV=4, BEEP_CYCLES=3.
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clearn;
  logic       digit_valid;
  logic [3:0] digit;
  logic       mag_on;
  logic       timer_done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
`ifdef TIMER_BEEP_EN
  logic       beep;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cook_timer #(.TICK_DIV(4), .BEEP_CYCLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clearn     (clearn),
    .digit_valid(digit_valid),
    .digit      (digit),
    .mag_on     (mag_on),
    .timer_done (timer_done),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones)
`ifdef TIMER_BEEP_EN
    ,
    .beep       (beep)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        clearn;
    logic        dv;
    logic [3:0]  digit;
    logic        mag;
    logic [15:0] cnt;
    logic        done;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] exp_cnt, input logic exp_done);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    n_checks++;
    if (got !== exp_cnt || timer_done !== exp_done) begin
      n_fail++;
      $display("FAIL %s: got %h done=%b, expected %h done=%b",
               name, got, timer_done, exp_cnt, exp_done);
    end
  endtask

`ifdef TIMER_BEEP_EN
  task automatic chk_beep(input string name, input logic exp_beep);
    n_checks++;
    if (beep !== exp_beep) begin
      n_fail++;
      $display("FAIL %s: beep got %b, expected %b", name, beep, exp_beep);
    end
  endtask
`endif

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic clr();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
  endtask

  initial begin
    // clearn, dv, digit, mag, expected MM:SS, expected done
    vecs[0]  = {1'b1, 1'b1, 4'd1,  1'b0, 16'h0001, 1'b0};
    vecs[1]  = {1'b1, 1'b1, 4'd3,  1'b0, 16'h0013, 1'b0};
    vecs[2]  = {1'b1, 1'b1, 4'd0,  1'b0, 16'h0130, 1'b0};
    vecs[3]  = {1'b1, 1'b1, 4'd10, 1'b0, 16'h0130, 1'b0};
    vecs[4]  = {1'b1, 1'b1, 4'd5,  1'b0, 16'h1305, 1'b0};
    vecs[5]  = {1'b1, 1'b1, 4'd9,  1'b0, 16'h3059, 1'b0};
    vecs[6]  = {1'b1, 1'b1, 4'd2,  1'b0, 16'h0592, 1'b0};
    vecs[7]  = {1'b0, 1'b1, 4'd8,  1'b0, 16'h0000, 1'b0};
    vecs[8]  = {1'b1, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0};
    vecs[9]  = {1'b1, 1'b1, 4'd4,  1'b1, 16'h0000, 1'b1};
    vecs[10] = {1'b1, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b1};
    vecs[11] = {1'b1, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1};
    vecs[12] = {1'b1, 1'b1, 4'd7,  1'b0, 16'h0007, 1'b0};
    vecs[13] = {1'b1, 1'b1, 4'd1,  1'b0, 16'h0071, 1'b0};

    rst_n = 1'b0; clearn = 1'b1; digit_valid = 1'b0; digit = 4'd0; mag_on = 1'b0;
    #22;
    chk("reset", 16'h0000, 1'b0);
`ifdef TIMER_BEEP_EN
    chk_beep("reset_beep", 1'b0);
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      clearn      = vecs[i].clearn;
      digit_valid = vecs[i].dv;
      digit       = vecs[i].digit;
      mag_on      = vecs[i].mag;
      step();
      chk($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].done);
    end
    digit_valid = 1'b0; clearn = 1'b1; mag_on = 1'b0;
    clr();

    // 01:30 countdown with minute borrow
    key(4'd1); key(4'd3); key(4'd0);
    chk("set_0130", 16'h0130, 1'b0);
    mag_on = 1'b1;
    repeat (3) step();
    chk("run3_0130", 16'h0130, 1'b0);
    step();
    chk("run4_0129", 16'h0129, 1'b0);
    repeat (119) step();
    chk("run123_0100", 16'h0100, 1'b0);
    step();
    chk("run124_0059", 16'h0059, 1'b0);
    mag_on = 1'b0;
    clr();

    // 00:02 to done, beep window
    key(4'd2);
    mag_on = 1'b1;
    repeat (3) step();
    chk("b_c3", 16'h0002, 1'b0);
    step();
    chk("b_c4", 16'h0001, 1'b0);
    repeat (3) step();
    chk("b_c7", 16'h0001, 1'b0);
`ifdef TIMER_BEEP_EN
    chk_beep("b_c7_beep", 1'b0);
`endif
    step();
    chk("b_c8_done", 16'h0000, 1'b1);
`ifdef TIMER_BEEP_EN
    chk_beep("b_c8_beep", 1'b1);
    step(); chk_beep("b_c9_beep", 1'b1);
    step(); chk_beep("b_c10_beep", 1'b1);
    step(); chk_beep("b_c11_beep", 1'b0);
`endif
    repeat (4) step();
    chk("b_no_underflow", 16'h0000, 1'b1);
    mag_on = 1'b0;
    step();
    chk("b_done_holds", 16'h0000, 1'b1);
    clr();
    chk("b_cleared", 16'h0000, 1'b0);

    // Pause keeps the partial second
    key(4'd5);
    mag_on = 1'b1;
    repeat (4) step();
    chk("p_tick1", 16'h0004, 1'b0);
    repeat (2) step();
    mag_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("p_hold%0d", i), 16'h0004, 1'b0);
    end
    mag_on = 1'b1;
    step();
    chk("p_resume1", 16'h0004, 1'b0);
    step();
    chk("p_resume2", 16'h0003, 1'b0);
    mag_on = 1'b0;
    clr();

    // Clear wins over a coincident tick and digit strobe
    key(4'd3);
    mag_on = 1'b1;
    repeat (3) step();
    clearn = 1'b0; digit_valid = 1'b1; digit = 4'd4;
    step();
    chk("c_clear_wins", 16'h0000, 1'b0);
    clearn = 1'b1; digit_valid = 1'b0; mag_on = 1'b0;
    step();
    chk("c_idle", 16'h0000, 1'b0);
    key(4'd1);
    mag_on = 1'b1;
    repeat (3) step();
    chk("c_presc_zeroed", 16'h0001, 1'b0);
    step();
    chk("c_done", 16'h0000, 1'b1);
    mag_on = 1'b0;
    clr();

    // Seconds above 59 and tens-of-minutes borrow
    key(4'd1); key(4'd9); key(4'd0);
    mag_on = 1'b1;
    repeat (4) step();
    chk("s_0189", 16'h0189, 1'b0);
    mag_on = 1'b0;
    clr();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    mag_on = 1'b1;
    repeat (4) step();
    chk("s_0959", 16'h0959, 1'b0);
    mag_on = 1'b0;
    clr();

    // Asynchronous reset mid-count
    key(4'd3);
    mag_on = 1'b1;
    repeat (2) step();
    chk("r_pre", 16'h0003, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async", 16'h0000, 1'b0);
    mag_on = 1'b0;
    #3;
    rst_n = 1'b1;
    repeat (3) step();
    chk("r_after_release", 16'h0000, 1'b0);
    mag_on = 1'b1;
    step();
    chk("r_idle_start", 16'h0000, 1'b1);
    mag_on = 1'b0;
    clr();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
